// File: rtl/dbg_pkg.sv
// Shared types for the host-to-core debug command channel.
package dbg_pkg;

    typedef enum logic [2:0] {
        OP_NOP         = 3'd0,
        OP_HALT        = 3'd1,
        OP_RESUME      = 3'd2,
        OP_STEP        = 3'd3,
        OP_SET_BP      = 3'd4,
        OP_CLR_BP      = 3'd5,
        OP_READ_PC     = 3'd6,
        OP_READ_STATUS = 3'd7
    } dbg_op_e;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALTED = 2'd1,
        ST_STEP   = 2'd2
    } dbg_state_e;

    typedef enum logic [2:0] {
        CAUSE_NONE   = 3'd0,
        CAUSE_HOST   = 3'd1,
        CAUSE_BKPT   = 3'd2,
        CAUSE_STEP   = 3'd3,
        CAUSE_EBREAK = 3'd4
    } dbg_cause_e;

    // Status word returned by READ_STATUS: {27'b0, cause, state}.
    function automatic logic [31:0] pack_status(input dbg_cause_e c, input dbg_state_e s);
        return {27'b0, c, s};
    endfunction

endpackage

// File: rtl/dbg_bkpt_cmp.sv
// PC breakpoint table: NUM_BP slots with enables, one write port and a
// combinational hit flag that ORs every enabled exact-PC match.
module dbg_bkpt_cmp
    import dbg_pkg::*;
#(
    parameter int NUM_BP = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic        wr_set,
    input  logic [2:0]  wr_idx,
    input  logic [31:0] wr_pc,
    input  logic [31:0] cmp_pc,
    output logic        hit
);

    logic [NUM_BP-1:0] en;
    logic [31:0]       bp_pc [NUM_BP];

    // Slot enables: set on SET_BP, cleared on CLR_BP and by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NUM_BP; i++) begin
                if (wr_idx == 3'(i)) en[i] <= wr_set;
            end
        end
    end

    // Breakpoint addresses are plain data; they are only looked at when enabled.
    always_ff @(posedge clk) begin
        if (wr_en && wr_set) begin
            for (int i = 0; i < NUM_BP; i++) begin
                if (wr_idx == 3'(i)) bp_pc[i] <= wr_pc;
            end
        end
    end

    // Any enabled slot matching the retiring PC raises hit.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < NUM_BP; i++) begin
            if (en[i] && (bp_pc[i] == cmp_pc)) hit = 1'b1;
        end
    end

endmodule

// File: rtl/dbg_ctrl.sv
// Debug control: accepts host commands, runs the RUN/HALTED/STEP FSM that
// drives core_halt, watches the commit stream for halt events and returns
// exactly one response per accepted command.
module dbg_ctrl
    import dbg_pkg::*;
#(
    parameter int NUM_BP        = 4,
    parameter bit HALT_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [2:0]  cmd_idx,
    input  logic [31:0] cmd_arg,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_err,
    output logic [31:0] rsp_data,
    input  logic        commit_valid,
    input  logic [31:0] commit_pc,
    input  logic        commit_brk,
    output logic        core_halt
);

    localparam dbg_state_e RESET_STATE = HALT_ON_RESET ? ST_HALTED : ST_RUN;

    dbg_state_e  state, state_nxt;
    dbg_cause_e  cause, cause_nxt, ev_cause;
    logic [31:0] last_pc;
    logic        rsp_err_nxt;
    logic [31:0] rsp_data_nxt;
    logic        accept;
    logic        commit_live;
    logic        idx_ok;
    logic        bp_wr_en;
    logic        bp_wr_set;
    logic        bp_hit;
    dbg_op_e     op;

    assign op          = dbg_op_e'(cmd_op);
    assign cmd_ready   = !rsp_valid;
    assign accept      = cmd_valid && cmd_ready;
    assign core_halt   = (state == ST_HALTED);
    assign commit_live = commit_valid && (state != ST_HALTED);
    assign idx_ok      = ({1'b0, cmd_idx} < 4'(NUM_BP));

    dbg_bkpt_cmp #(
        .NUM_BP (NUM_BP)
    ) u_bkpt (
        .clk    (clk),
        .reset  (reset),
        .wr_en  (bp_wr_en),
        .wr_set (bp_wr_set),
        .wr_idx (cmd_idx),
        .wr_pc  (cmd_arg),
        .cmp_pc (commit_pc),
        .hit    (bp_hit)
    );

    // FSM state, halt cause and the last retired PC.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= RESET_STATE;
            cause   <= CAUSE_NONE;
            last_pc <= '0;
        end else begin
            state <= state_nxt;
            cause <= cause_nxt;
            if (commit_live) last_pc <= commit_pc;
        end
    end

    // Response register: loaded on accept, held until the host takes it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_data  <= '0;
        end else if (accept) begin
            rsp_valid <= 1'b1;
            rsp_err   <= rsp_err_nxt;
            rsp_data  <= rsp_data_nxt;
        end else if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_data  <= '0;
        end
    end

    // Next state, cause, response and breakpoint writes. Commit events are
    // applied last so they override any same-cycle command transition; the
    // command itself is still answered normally.
    always_comb begin
        state_nxt    = state;
        cause_nxt    = cause;
        rsp_err_nxt  = 1'b0;
        rsp_data_nxt = '0;
        bp_wr_en     = 1'b0;
        bp_wr_set    = 1'b0;
        ev_cause     = CAUSE_NONE;

        if (commit_live) begin
            if (commit_brk)              ev_cause = CAUSE_EBREAK;
            else if (bp_hit)             ev_cause = CAUSE_BKPT;
            else if (state == ST_STEP)   ev_cause = CAUSE_STEP;
        end

        if (accept) begin
            case (op)
                OP_HALT: begin
                    if (state != ST_HALTED) begin
                        state_nxt = ST_HALTED;
                        cause_nxt = CAUSE_HOST;
                    end
                end
                OP_RESUME: begin
                    if (state != ST_RUN) state_nxt = ST_RUN;
                end
                OP_STEP: begin
                    if (state == ST_HALTED) state_nxt = ST_STEP;
                    else                    rsp_err_nxt = 1'b1;
                end
                OP_SET_BP: begin
                    if (idx_ok) begin
                        bp_wr_en  = 1'b1;
                        bp_wr_set = 1'b1;
                    end else begin
                        rsp_err_nxt = 1'b1;
                    end
                end
                OP_CLR_BP: begin
                    if (idx_ok) bp_wr_en    = 1'b1;
                    else        rsp_err_nxt = 1'b1;
                end
                OP_READ_PC:     rsp_data_nxt = last_pc;
                OP_READ_STATUS: rsp_data_nxt = pack_status(cause, state);
                default: ;
            endcase
        end

        if (ev_cause != CAUSE_NONE) begin
            state_nxt = ST_HALTED;
            cause_nxt = ev_cause;
        end
    end

endmodule

// File: tb/tb_dbg_ctrl.sv
// Directed bench for dbg_ctrl with a response scoreboard.
module tb_dbg_ctrl;
    import dbg_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [2:0]  cmd_idx;
    logic [31:0] cmd_arg;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_err;
    logic [31:0] rsp_data;
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic        commit_brk;
    logic        core_halt;

    int n_asrt = 0;
    int n_fail = 0;
    logic [32:0] exp_q[$];

    dbg_ctrl #(
        .NUM_BP        (4),
        .HALT_ON_RESET (1'b1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_idx      (cmd_idx),
        .cmd_arg      (cmd_arg),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_err      (rsp_err),
        .rsp_data     (rsp_data),
        .commit_valid (commit_valid),
        .commit_pc    (commit_pc),
        .commit_brk   (commit_brk),
        .core_halt    (core_halt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for a response, compare it with the scoreboard head,
    // then let it be consumed with rsp_ready high.
    task automatic check_rsp(input string tag);
        int n;
        logic [32:0] e;
        n = 0;
        while (!rsp_valid && n < 10) begin
            tick();
            n++;
        end
        chk({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 32'd1);
        chk({tag, "_sb_nonempty"}, (exp_q.size() != 0) ? 32'd1 : 32'd0, 32'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk({tag, "_err"}, {31'b0, rsp_err}, {31'b0, e[32]});
            chk({tag, "_data"}, rsp_data, e[31:0]);
        end
        tick();
    endtask

    task automatic drive_cmd(input dbg_op_e op, input logic [2:0] idx, input logic [31:0] arg,
                             input logic e_err, input logic [31:0] e_data);
        int n;
        n = 0;
        while (!cmd_ready && n < 10) begin
            tick();
            n++;
        end
        chk("cmd_ready_before_cmd", {31'b0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_idx   = idx;
        cmd_arg   = arg;
        exp_q.push_back({e_err, e_data});
    endtask

    task automatic do_cmd(input string tag, input dbg_op_e op, input logic [2:0] idx,
                          input logic [31:0] arg, input logic e_err, input logic [31:0] e_data);
        drive_cmd(op, idx, arg, e_err, e_data);
        tick();
        cmd_valid = 1'b0;
        check_rsp(tag);
    endtask

    task automatic commit(input logic [31:0] pc, input logic brk);
        commit_valid = 1'b1;
        commit_pc    = pc;
        commit_brk   = brk;
        tick();
        commit_valid = 1'b0;
        commit_brk   = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        cmd_valid    = 1'b0;
        cmd_op       = 3'd0;
        cmd_idx      = 3'd0;
        cmd_arg      = 32'd0;
        rsp_ready    = 1'b1;
        commit_valid = 1'b0;
        commit_pc    = 32'd0;
        commit_brk   = 1'b0;

        // 1: reset state, halted out of reset
        tick();
        tick();
        chk("rst_core_halt", {31'b0, core_halt}, 32'd1);
        chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        reset = 1'b0;
        tick();
        chk("post_rst_core_halt", {31'b0, core_halt}, 32'd1);
        do_cmd("status_reset", OP_READ_STATUS, 3'd0, 32'd0, 1'b0, 32'h1);

        // 2: resume and retire two instructions
        do_cmd("resume1", OP_RESUME, 3'd0, 32'd0, 1'b0, 32'd0);
        chk("run_core_halt", {31'b0, core_halt}, 32'd0);
        commit(32'h8000_0000, 1'b0);
        commit(32'h8000_0004, 1'b0);
        chk("run_core_halt2", {31'b0, core_halt}, 32'd0);
        do_cmd("read_pc1", OP_READ_PC, 3'd0, 32'd0, 1'b0, 32'h8000_0004);
        do_cmd("status_run", OP_READ_STATUS, 3'd0, 32'd0, 1'b0, 32'h0);

        // 3: breakpoint hit halts after the matching commit
        do_cmd("set_bp2", OP_SET_BP, 3'd2, 32'h8000_0010, 1'b0, 32'd0);
        do_cmd("resume_run", OP_RESUME, 3'd0, 32'd0, 1'b0, 32'd0);
        commit(32'h8000_0008, 1'b0);
        chk("no_hit_core_halt", {31'b0, core_halt}, 32'd0);
        commit(32'h8000_0010, 1'b0);
        chk("bp_core_halt", {31'b0, core_halt}, 32'd1);
        do_cmd("status_bp", OP_READ_STATUS, 3'd0, 32'd0, 1'b0, 32'h09);
        do_cmd("read_pc_bp", OP_READ_PC, 3'd0, 32'd0, 1'b0, 32'h8000_0010);

        // 4: single step, then STEP rejected while running
        do_cmd("step", OP_STEP, 3'd0, 32'd0, 1'b0, 32'd0);
        chk("step_core_halt_low", {31'b0, core_halt}, 32'd0);
        tick();
        chk("step_core_halt_low2", {31'b0, core_halt}, 32'd0);
        commit(32'h8000_0014, 1'b0);
        chk("step_core_halt_high", {31'b0, core_halt}, 32'd1);
        do_cmd("status_step", OP_READ_STATUS, 3'd0, 32'd0, 1'b0, 32'h0D);
        do_cmd("resume2", OP_RESUME, 3'd0, 32'd0, 1'b0, 32'd0);
        do_cmd("step_in_run", OP_STEP, 3'd0, 32'd0, 1'b1, 32'd0);
        do_cmd("status_after_bad_step", OP_READ_STATUS, 3'd0, 32'd0, 1'b0, 32'h0C);
        do_cmd("halt_host", OP_HALT, 3'd0, 32'd0, 1'b0, 32'd0);
        do_cmd("status_host", OP_READ_STATUS, 3'd0, 32'd0, 1'b0, 32'h05);
        // breakpoint outranks the step cause
        do_cmd("step_onto_bp", OP_STEP, 3'd0, 32'd0, 1'b0, 32'd0);
        commit(32'h8000_0010, 1'b0);
        do_cmd("status_step_bp", OP_READ_STATUS, 3'd0, 32'd0, 1'b0, 32'h09);

        // 5: HALT together with ebreak reports the ebreak cause
        do_cmd("resume3", OP_RESUME, 3'd0, 32'd0, 1'b0, 32'd0);
        drive_cmd(OP_HALT, 3'd0, 32'd0, 1'b0, 32'd0);
        commit_valid = 1'b1;
        commit_pc    = 32'h8000_0018;
        commit_brk   = 1'b1;
        tick();
        cmd_valid    = 1'b0;
        commit_valid = 1'b0;
        commit_brk   = 1'b0;
        chk("ebrk_core_halt", {31'b0, core_halt}, 32'd1);
        check_rsp("halt_with_ebrk");
        do_cmd("status_ebrk", OP_READ_STATUS, 3'd0, 32'd0, 1'b0, 32'h11);
        do_cmd("set_bp_bad_idx", OP_SET_BP, 3'd5, 32'h8000_0020, 1'b1, 32'd0);
        do_cmd("clr_bp_bad_idx", OP_CLR_BP, 3'd7, 32'd0, 1'b1, 32'd0);
        do_cmd("resume4", OP_RESUME, 3'd0, 32'd0, 1'b0, 32'd0);
        commit(32'h8000_0020, 1'b0);
        chk("bad_idx_no_hit", {31'b0, core_halt}, 32'd0);
        do_cmd("clr_bp2", OP_CLR_BP, 3'd2, 32'd0, 1'b0, 32'd0);
        commit(32'h8000_0010, 1'b0);
        chk("cleared_no_hit", {31'b0, core_halt}, 32'd0);
        do_cmd("read_pc2", OP_READ_PC, 3'd0, 32'd0, 1'b0, 32'h8000_0010);
        do_cmd("status_run_ebrk", OP_READ_STATUS, 3'd0, 32'd0, 1'b0, 32'h10);
        // same-cycle SET_BP and commit: the commit sees the old table
        drive_cmd(OP_SET_BP, 3'd0, 32'h8000_0030, 1'b0, 32'd0);
        commit_valid = 1'b1;
        commit_pc    = 32'h8000_0030;
        tick();
        cmd_valid    = 1'b0;
        commit_valid = 1'b0;
        chk("setbp_same_cycle_no_hit", {31'b0, core_halt}, 32'd0);
        check_rsp("set_bp0");
        commit(32'h8000_0030, 1'b0);
        chk("setbp_next_hit", {31'b0, core_halt}, 32'd1);
        do_cmd("status_bp0", OP_READ_STATUS, 3'd0, 32'd0, 1'b0, 32'h09);

        // 6: response held under backpressure, then reset drops it
        rsp_ready = 1'b0;
        drive_cmd(OP_READ_PC, 3'd0, 32'd0, 1'b0, 32'h8000_0030);
        tick();
        cmd_valid = 1'b0;
        begin
            logic [32:0] e;
            e = exp_q.pop_front();
            for (int i = 0; i < 3; i++) begin
                chk("hold_rsp_valid", {31'b0, rsp_valid}, 32'd1);
                chk("hold_rsp_data", rsp_data, e[31:0]);
                chk("hold_rsp_err", {31'b0, rsp_err}, {31'b0, e[32]});
                chk("hold_cmd_ready", {31'b0, cmd_ready}, 32'd0);
                tick();
            end
        end
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("midrst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        chk("midrst_core_halt", {31'b0, core_halt}, 32'd1);
        tick();
        reset     = 1'b0;
        rsp_ready = 1'b1;
        tick();
        do_cmd("status_after_rst", OP_READ_STATUS, 3'd0, 32'd0, 1'b0, 32'h1);
        do_cmd("read_pc_after_rst", OP_READ_PC, 3'd0, 32'd0, 1'b0, 32'h0);
        do_cmd("resume_after_rst", OP_RESUME, 3'd0, 32'd0, 1'b0, 32'd0);
        commit(32'h8000_0030, 1'b0);
        chk("bp_cleared_by_rst", {31'b0, core_halt}, 32'd0);

        chk("sb_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
